// File: rtl/tcdm_bank_responder.sv
// TCDM slave endpoint: byte-enabled word SRAM model with a fixed-latency response pipeline,
// optional LFSR-driven grant stalling (at most 3 stalls in a row) and an out-of-range counter.
module tcdm_bank_responder #(
    parameter int unsigned NUM_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [31:0] ERR_DATA   = 32'hBADC_AB1E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        test_mode_i,
    input  logic        stall_en_i,
    input  logic        req_i,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic [31:0] r_rdata_o,
    output logic        r_valid_o,
    output logic [7:0]  err_cnt_o
);

    localparam int unsigned AW       = $clog2(NUM_WORDS);
    // One bit wider so a bank ending at the top of the address space does not wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(NUM_WORDS) * 33'd4;

    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  stall_cnt_q, stall_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic          stall;
    logic          accept;
    logic          in_range;
    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic [31:0]   rd_word;
    logic [31:0]   resp_data;
    logic          unused_offset;

    logic [31:0]           mem [NUM_WORDS];
    logic [RD_LATENCY-1:0] vld_q;
    logic [31:0]           dat_q [RD_LATENCY];

    always_comb begin
        offset   = add_i - BASE_ADDR;
        index    = offset[AW+1:2];
        in_range = ({1'b0, add_i} >= {1'b0, BASE_ADDR}) && ({1'b0, add_i} < END_ADDR);
    end

    // Byte-offset bits and the out-of-bank upper bits never select a word.
    assign unused_offset = ^offset;

    always_comb begin
        stall  = stall_en_i & ~test_mode_i & lfsr_q[0] & (stall_cnt_q != 2'd3);
        gnt_o  = req_i & ~stall;
        accept = req_i & ~stall;

        lfsr_d = lfsr_q;
        if (stall_en_i) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end

        stall_cnt_d = 2'd0;
        if (req_i && !accept) begin
            stall_cnt_d = stall_cnt_q + 2'd1;
        end

        err_cnt_d = err_cnt_q;
        if (accept && !in_range && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q      <= 16'hACE1;
            stall_cnt_q <= 2'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            lfsr_q      <= lfsr_d;
            stall_cnt_q <= stall_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive a mid-run reset.
    always_ff @(posedge clk_i) begin
        if (accept && !wen_i && in_range && !rst_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[index][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word   = in_range ? mem[index] : ERR_DATA;
        resp_data = wen_i ? rd_word : 32'h0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            vld_q[0] <= accept;
            dat_q[0] <= accept ? resp_data : 32'h0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    always_comb begin
        r_valid_o = vld_q[RD_LATENCY-1];
        r_rdata_o = r_valid_o ? dat_q[RD_LATENCY-1] : 32'h0;
        err_cnt_o = err_cnt_q;
    end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Scoreboard bench for tcdm_bank_responder: directed requests carry hand-computed expected
// responses; a negedge monitor checks grant, latency, data and the error counter.
module tb_tcdm_bank_responder;

    localparam int unsigned LAT  = 3;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] ERRD = 32'hBADC_AB1E;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        test_mode = 1'b0;
    logic        stall_en = 1'b0;
    logic        req = 1'b0;
    logic [31:0] add = 32'h0;
    logic        wen = 1'b1;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    logic        gnt;
    logic [31:0] r_rdata;
    logic        r_valid;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    tcdm_bank_responder #(
        .NUM_WORDS  (1024),
        .BASE_ADDR  (BASE),
        .RD_LATENCY (LAT),
        .ERR_DATA   (ERRD)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .test_mode_i (test_mode),
        .stall_en_i  (stall_en),
        .req_i       (req),
        .add_i       (add),
        .wen_i       (wen),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt),
        .r_rdata_o   (r_rdata),
        .r_valid_o   (r_valid),
        .err_cnt_o   (err_cnt)
    );

    typedef struct packed {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] pend_q[$];
    exp_t        mon_e;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    logic [1:0]  scnt_m = 2'd0;
    int unsigned err_m = 0;
    bit          mon_en = 1'b0;
    int          stall_run = 0;
    int unsigned stalls_seen = 0;
    int unsigned grants = 0;
    int unsigned resps = 0;

    function automatic logic gnt_m();
        return req & ~(stall_en & ~test_mode & lfsr_m[0] & (scnt_m != 2'd3));
    endfunction

    function automatic logic in_range_m(input logic [31:0] a);
        return (a >= 32'h1000_0000) && (a < 32'h1000_1000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: acceptance, stall counter, LFSR and error count from the spec rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_m <= 16'hACE1;
            scnt_m <= 2'd0;
            err_m  <= 0;
            sb_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (gnt_m()) begin
                grants <= grants + 1;
                if (pend_q.size() != 0) begin
                    sb_q.push_back('{due: cyc + LAT, data: pend_q.pop_front()});
                end else begin
                    errors <= errors + 1;
                    $display("FAIL unexpected_accept: no pending request at t=%0t", $time);
                end
                if (!in_range_m(add) && err_m != 255) err_m <= err_m + 1;
                scnt_m <= 2'd0;
            end else if (req) begin
                scnt_m <= scnt_m + 2'd1;
            end else begin
                scnt_m <= 2'd0;
            end
            if (stall_en) begin
                lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                chk("valid_in_reset", {31'h0, r_valid}, 32'h0);
            end else begin
                chk("gnt", {31'h0, gnt}, {31'h0, gnt_m()});
                chk("err_cnt", {24'h0, err_cnt}, {24'h0, err_m[7:0]});
                if (req && !gnt) begin
                    stall_run++;
                    stalls_seen++;
                end else begin
                    stall_run = 0;
                end
                chk("max_3_stalls", {31'h0, (stall_run > 3)}, 32'h0);
                if (r_valid) begin
                    resps++;
                    if (sb_q.size() == 0) begin
                        chk("spurious_rvalid", {31'h0, r_valid}, 32'h0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("resp_cycle", cyc, mon_e.due);
                        chk("rdata", r_rdata, mon_e.data);
                    end
                end else begin
                    chk("rdata_idle", r_rdata, 32'h0);
                    if (sb_q.size() != 0) begin
                        chk("resp_missing", {31'h0, (sb_q[0].due <= cyc)}, 32'h0);
                        if (sb_q[0].due <= cyc) mon_e = sb_q.pop_front();
                    end
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] exp_v);
        int n;
        n = 0;
        pend_q.push_back(exp_v);
        req = 1'b1;
        wen = w;
        add = a;
        wdata = d;
        be = b;
        @(negedge clk);
        while (!gnt_m() && n < 8) begin
            n++;
            @(negedge clk);
        end
        if (n >= 8) begin
            chk("grant_timeout", 32'h1, 32'h0);
            pend_q.delete();
            req = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drained", sb_q.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rvalid", {31'h0, r_valid}, 32'h0);
        chk("reset_rdata", r_rdata, 32'h0);
        chk("reset_err", {24'h0, err_cnt}, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Write then read next cycle; write response carries zero data.
        issue(1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
        issue(1'b1, 32'h1000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF);
        // Partial byte-enable merge.
        issue(1'b0, 32'h1000_0020, 32'h1122_3344, 4'hF, 32'h0);
        issue(1'b0, 32'h1000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0);
        issue(1'b1, 32'h1000_0020, 32'h0, 4'h0, 32'h11BB_33DD);
        // be=0 write is a no-op that still responds.
        issue(1'b0, 32'h1000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0);
        issue(1'b1, 32'h1000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF);
        drain();

        // Streaming: 8 writes then 8 back-to-back reads; one read uses a misaligned address.
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 32'h1000_0100 + 32'(4 * i), 32'hA500_0000 | 32'(i), 4'hF, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, (32'h1000_0100 + 32'(4 * i)) | ((i == 3) ? 32'h3 : 32'h0), 32'h0, 4'h0,
                  32'hA500_0000 | 32'(i));
        end
        drain();

        // Boundaries: first and last word, then out-of-range read and write.
        issue(1'b0, 32'h1000_0000, 32'h0000_C0DE, 4'hF, 32'h0);
        issue(1'b0, 32'h1000_0FFC, 32'hFEED_F00D, 4'hF, 32'h0);
        issue(1'b1, 32'h1000_0FFC, 32'h0, 4'h0, 32'hFEED_F00D);
        issue(1'b1, 32'h0FFF_FFFC, 32'h0, 4'h0, ERRD);
        issue(1'b0, 32'h1000_1000, 32'h1234_5678, 4'hF, 32'h0);
        issue(1'b1, 32'h1000_0000, 32'h0, 4'h0, 32'h0000_C0DE);
        drain();
        chk("err_cnt_two", {24'h0, err_cnt}, 32'd2);

        // Stall stress with request held continuously.
        stall_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(1'b1, ((i % 2) == 0) ? 32'h1000_0010 : 32'h1000_0020, 32'h0, 4'h0,
                  ((i % 2) == 0) ? 32'hDEAD_BEEF : 32'h11BB_33DD);
        end
        drain();
        chk("stalls_occurred", {31'h0, (stalls_seen > 0)}, 32'h1);
        chk("resp_eq_grant", resps, grants);

        // Test mode overrides stalling.
        test_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            issue(1'b1, 32'h1000_0100 + 32'(4 * (i % 8)), 32'h0, 4'h0, 32'hA500_0000 | 32'(i % 8));
        end
        idle(3);
        test_mode = 1'b0;
        stall_en = 1'b0;
        drain();

        // Saturation: writes at 0x2000_0000 would alias word 0 if the range check were missing.
        for (int i = 0; i < 300; i++) begin
            issue(1'b0, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0);
        end
        drain();
        chk("err_cnt_sat", {24'h0, err_cnt}, 32'd255);
        issue(1'b1, 32'h1000_0000, 32'h0, 4'h0, 32'h0000_C0DE);
        drain();

        // Asynchronous reset with two reads in flight.
        issue(1'b1, 32'h1000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF);
        issue(1'b1, 32'h1000_0020, 32'h0, 4'h0, 32'h11BB_33DD);
        @(posedge clk);
        #2;
        chk("rvalid_before_reset", {31'h0, r_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rvalid_async_drop", {31'h0, r_valid}, 32'h0);
        chk("rdata_async_drop", r_rdata, 32'h0);
        idle(2);
        rst = 1'b0;
        idle(6);
        chk("err_after_reset", {24'h0, err_cnt}, 32'h0);
        issue(1'b1, 32'h1000_0020, 32'h0, 4'h0, 32'h11BB_33DD);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- TCDM slave endpoint: the memory-side responder that answers a TCDM master such as the accelerator's tcdm_bus port.
- Holds a word-addressed SRAM model with byte enables and a configurable read-response latency.
- Optional pseudo-random grant stalling with a bounded-starvation guarantee, to stress master-side handshake logic.
- Out-of-range accesses are always answered and counted, never hung.

Parameters:
- NUM_WORDS, 1024, number of 32-bit words in the bank (power of 2, >= 2)
- BASE_ADDR, 32'h1000_0000, byte address of word 0 (word aligned)
- RD_LATENCY, 1, cycles from accepting edge to response (1..4)
- ERR_DATA, 32'hBADC_AB1E, read data returned for out-of-range reads

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- test_mode_i  in  1  when 1, forces stalling off (gnt_o = req_i)
- stall_en_i  in  1  enables pseudo-random grant stalling
- req_i  in  1  request valid
- add_i  in  32  byte address
- wen_i  in  1  1 = read, 0 = write (TCDM convention)
- wdata_i  in  32  write data
- be_i  in  4  byte enables; be_i[k] covers wdata_i[8k+7:8k]
- gnt_o  out  1  grant; combinational from req_i and stall state
- r_rdata_o  out  32  response data
- r_valid_o  out  1  response valid, one-cycle pulse per accepted request
- err_cnt_o  out  8  saturating count of out-of-range accesses

Behaviour:
- Reset values:
  - r_valid_o=0, r_rdata_o=0, err_cnt_o=0.
  - LFSR=16'hACE1, stall counter=0, response pipeline cleared.
  - Memory contents are not reset.
- Accept: a request is accepted in cycle N when req_i=1 and gnt_o=1 at the rising edge ending N. No request is queued; an ungranted request is ignored.
- Grant:
  - gnt_o = req_i & ~stall.
  - stall = stall_en_i & ~test_mode_i & lfsr[0] & (stall_cnt != 3).
- Stall counter:
  - Increments on each edge where req_i=1 and gnt_o=0.
  - Clears on any edge with an accepted request or with req_i=0.
  - Effect: at most 3 consecutive stalled cycles; the 4th cycle is always granted.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts left, feedback into bit 0.
  - Advances every edge while stall_en_i=1; holds otherwise.
- Address decode:
  - in_range = (add_i >= BASE_ADDR) && (add_i < BASE_ADDR + 4*NUM_WORDS).
  - index = (add_i - BASE_ADDR) >> 2; add_i[1:0] is ignored.
- Write (accepted, wen_i=0, in range):
  - Bytes with be_i[k]=1 are updated at the accepting edge; other bytes are unchanged.
  - be_i=0 is a legal no-op write that still responds.
- Read (accepted, wen_i=1, in range): memory is sampled at the accepting edge. A read accepted in the cycle after a write to the same word returns the new data.
- Response:
  - Exactly one r_valid_o pulse in cycle N+RD_LATENCY for every accepted request, reads and writes alike.
  - r_rdata_o = read data for reads; 0 for writes.
  - Responses come back in acceptance order. Back-to-back accepts give back-to-back responses; the pipeline has RD_LATENCY stages and never stalls.
- When r_valid_o=0, r_rdata_o=0.
- Out of range:
  - The access is granted and responded normally; writes are dropped, reads return ERR_DATA.
  - err_cnt_o increments at the accepting edge and saturates at 255.
- Reset mid-operation: in-flight responses are discarded, no r_valid_o pulse appears for them, and memory contents are retained.

Test Plan:
- Write 32'hDEAD_BEEF to 0x1000_0010 with be=4'hF, then read 0x1000_0010 the next cycle; RD_LATENCY=1 → read r_valid_o in the cycle after accept, r_rdata_o=32'hDEAD_BEEF, write response r_rdata_o=0.
- Write 32'h1122_3344 with be=F, then write 32'hAABB_CCDD with be=4'b0101 to the same word, then read → 32'h11BB_33DD.
- Streaming: 8 back-to-back reads with stall_en_i=0 and RD_LATENCY=3 → gnt_o=1 on all 8, r_valid_o high for 8 consecutive cycles starting 3 cycles after the first accept, data in order.
- stall_en_i=1 with req_i held for 200 cycles → never 4 consecutive gnt_o=0 cycles, and the r_valid_o count equals the grant count. Setting test_mode_i=1 → gnt_o=req_i.
- Read 0x0FFF_FFFC and write 0x1000_1000 (NUM_WORDS=1024) → read returns 32'hBADC_AB1E, err_cnt_o=2, and memory word 0 is unchanged. 300 out-of-range accesses → err_cnt_o=255.
- Assert rst_i asynchronously with 2 reads in flight (RD_LATENCY=4) → r_valid_o drops immediately with no late pulses. A previously written word still reads back correctly after reset.
